// File: rtl/multiplication.sv
// Sequential 8x8 unsigned shift-add multiplier: one start, eight RUN cycles,
// one-cycle DONE pulse with the registered 16-bit product.
module multiplication (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {8'h00, multiplicand};
                    mplier_d = multiplier;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                // Last iteration: product takes the accumulator including this edge's add.
                if (cnt_q == 3'd7) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: doc/multiplication.md
MULTIPLICATION -- requirements
Module: multiplication

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The module SHALL have these ports, clock and reset first:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a multiply; sampled on the rising clk edge.
- multiplicand  input  8  unsigned operand A.
- multiplier  input  8  unsigned operand B.
- product  output  16  unsigned A*B, registered.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when product is updated.
REQ-003 The module SHALL have no parameters; operand width is fixed at 8 bits and product width at 16 bits.

Function
REQ-004 The block SHALL be a sequential shift-add multiplier with states IDLE, RUN and DONE, encoded in a 2-bit state register.
REQ-005 In IDLE with start=1 at rising edge E0, the block SHALL:
- latch multiplicand, zero-extended to 16 bits, into mcand_r;
- latch multiplier into mplier_r;
- clear the 16-bit accumulator acc_r;
- clear the 3-bit iteration counter cnt_r;
- go to RUN.
REQ-006 Operand inputs SHALL be sampled only at E0; changes afterwards SHALL NOT affect the result in flight.
REQ-007 On each RUN edge, the block SHALL:
- add mcand_r to acc_r if mplier_r[0]=1 (16-bit add, no carry out);
- shift mcand_r left by 1, zero fill;
- shift mplier_r right by 1, zero fill;
- increment cnt_r.
REQ-008 RUN SHALL last exactly 8 edges (E1..E8) regardless of operand values; there is no early termination on zero operands.
REQ-009 At E8, the block SHALL load product with the final accumulator value (including the E8 partial add) and go to DONE.
REQ-010 DONE SHALL last exactly one cycle; at E9 the block SHALL return to IDLE.
REQ-011 busy SHALL be 1 from after E0 until after E8, i.e. whenever state=RUN, and 0 otherwise.
REQ-012 done SHALL be 1 exactly when state=DONE (one cycle, from E8 to E9), and 0 otherwise.
REQ-013 product SHALL hold its value until the next E8 and SHALL NOT change at E0.
REQ-014 Latency from the start edge E0 to done high SHALL be 8 cycles; an accepted start SHALL be followed by exactly one done pulse unless reset intervenes.
REQ-015 start SHALL be ignored in RUN and DONE; no queuing.
REQ-016 With start held at 1 continuously, a new multiply SHALL begin at every edge where the state is IDLE, giving one result every 10 cycles.
REQ-017 Arithmetic SHALL be unsigned; 0xFF*0xFF=0xFE01 is the maximum result, and the product cannot overflow 16 bits.

Reset
REQ-018 When rst_n=0, the block SHALL immediately and asynchronously set:
- state=IDLE;
- product=0x0000, busy=0, done=0;
- acc_r, mcand_r, mplier_r and cnt_r to 0.
REQ-019 Reset asserted during RUN or DONE SHALL abort the operation, produce no done pulse, and clear product to 0.
REQ-020 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted as E0.

Verification
REQ-021 A=0x0C, B=0x0A, start pulsed at E0 -> busy=1 for 8 cycles; done=1 for one cycle after E8; product=0x0078.
REQ-022 A=0xFF, B=0xFF -> product=0xFE01 at done; A=0x00, B=0xFF -> product=0x0000, still with 8-cycle latency.
REQ-023 Start A=0x03, B=0x05; at E3 apply start=1 with A=0xFF, B=0xFF -> second start ignored; product=0x000F; only one done pulse.
REQ-024 Start A=0x10, B=0x10 after a previous result of 0x0078; assert rst_n=0 at E4 -> busy, done and product go to 0 immediately; no done pulse follows.
REQ-025 start tied to 1 with operands changing every cycle -> done pulses 10 cycles apart; each product equals the operands present at that run's E0.
REQ-026 Random regression of 1000 operand pairs -> product equals A*B at every done pulse, and product is stable between done pulses.
